vscale_htif_pcr_master: RTL

VSCALE_HTIF_PCR_MASTER -- requirements
Module: vscale_htif_pcr_master

---
 rtl/vscale_htif_pkg.sv | 7 +
 rtl/vscale_htif_pcr_master_if.sv | 39 +++
 rtl/vscale_htif_timeout_ctr.sv | 21 ++
 rtl/vscale_htif_pcr_master.sv | 73 +++++++
 4 files changed

// File: rtl/vscale_htif_pkg.sv
// vscale_htif_pkg: shared HTIF/CSR widths, PCR timeout default and PCR master FSM encoding
package vscale_htif_pkg;
    localparam int CSR_ADDR_WIDTH = 12;
    localparam int HTIF_PCR_WIDTH = 64;
    localparam int PCR_TIMEOUT_CYCLES = 255;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RSP} pcr_state_t;
endpackage

// File: rtl/vscale_htif_pcr_master_if.sv
// vscale_htif_pcr_master_if: host command/response and PCR request/response channels
interface vscale_htif_pcr_master_if
    import vscale_htif_pkg::*;
#(
    parameter int ADDR_W = CSR_ADDR_WIDTH,
    parameter int DATA_W = HTIF_PCR_WIDTH
);
    logic              host_cmd_valid;
    logic              host_cmd_ready;
    logic              host_cmd_rw;
    logic [ADDR_W-1:0] host_cmd_addr;
    logic [DATA_W-1:0] host_cmd_data;
    logic              host_rsp_valid;
    logic              host_rsp_ready;
    logic [DATA_W-1:0] host_rsp_data;
    logic              host_rsp_err;
    logic              htif_pcr_req_valid;
    logic              htif_pcr_req_ready;
    logic              htif_pcr_req_rw;
    logic [ADDR_W-1:0] htif_pcr_req_addr;
    logic [DATA_W-1:0] htif_pcr_req_data;
    logic              htif_pcr_resp_valid;
    logic              htif_pcr_resp_ready;
    logic [DATA_W-1:0] htif_pcr_resp_data;
    modport master (
        input  host_cmd_valid, host_cmd_rw, host_cmd_addr, host_cmd_data, host_rsp_ready,
        input  htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data,
        output host_cmd_ready, host_rsp_valid, host_rsp_data, host_rsp_err,
        output htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
        output htif_pcr_resp_ready
    );
    modport slave (
        output host_cmd_valid, host_cmd_rw, host_cmd_addr, host_cmd_data, host_rsp_ready,
        output htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data,
        input  host_cmd_ready, host_rsp_valid, host_rsp_data, host_rsp_err,
        input  htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
        input  htif_pcr_resp_ready
    );
endinterface

// File: rtl/vscale_htif_timeout_ctr.sv
// vscale_htif_timeout_ctr: WAIT-cycle counter, flags the cycle whose increment reaches LIMIT
module vscale_htif_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] TOP = CW'(LIMIT);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else if (i_load) r_cnt <= '0;
        else if (i_en && r_cnt != TOP) r_cnt <= r_cnt + 1'b1;
    end
    assign o_expired = i_en && r_cnt == LAST;
endmodule

// File: rtl/vscale_htif_pcr_master.sv
// vscale_htif_pcr_master: turns host CSR commands into single outstanding PCR transactions with timeout
module vscale_htif_pcr_master
    import vscale_htif_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = PCR_TIMEOUT_CYCLES,
    parameter int ADDR_W = CSR_ADDR_WIDTH,
    parameter int DATA_W = HTIF_PCR_WIDTH
) (
    input  logic clk,
    input  logic reset_n,
    vscale_htif_pcr_master_if.master bus,
    output logic [7:0] stale_cnt
);
    pcr_state_t        r_state;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic [7:0]        r_stale;
    logic              w_load;
    logic              w_en;
    logic              w_expired;
    assign w_load = r_state == ST_REQ && bus.htif_pcr_req_ready;
    assign w_en   = r_state == ST_WAIT && !bus.htif_pcr_resp_valid;
    vscale_htif_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_ctr (
        .clk(clk), .reset_n(reset_n), .i_load(w_load), .i_en(w_en), .o_expired(w_expired)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_stale    <= '0;
        end else begin
            // responses outside WAIT belong to an abandoned request
            if (r_state != ST_WAIT && bus.htif_pcr_resp_valid && r_stale != 8'hFF) r_stale <= r_stale + 8'd1;
            case (r_state)
                ST_IDLE: if (bus.host_cmd_valid) begin
                    r_rw    <= bus.host_cmd_rw;
                    r_addr  <= bus.host_cmd_addr;
                    r_data  <= bus.host_cmd_data;
                    r_state <= ST_REQ;
                end
                ST_REQ: if (bus.htif_pcr_req_ready) r_state <= ST_WAIT;
                ST_WAIT: if (bus.htif_pcr_resp_valid) begin
                    r_rsp_data <= bus.htif_pcr_resp_data;
                    r_rsp_err  <= 1'b0;
                    r_state    <= ST_RSP;
                end else if (w_expired) begin
                    r_rsp_data <= '0;
                    r_rsp_err  <= 1'b1;
                    r_state    <= ST_RSP;
                end
                ST_RSP: if (bus.host_rsp_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign bus.host_cmd_ready      = r_state == ST_IDLE;
    assign bus.host_rsp_valid      = r_state == ST_RSP;
    assign bus.host_rsp_data       = r_rsp_data;
    assign bus.host_rsp_err        = r_rsp_err;
    assign bus.htif_pcr_req_valid  = r_state == ST_REQ;
    assign bus.htif_pcr_req_rw     = r_rw;
    assign bus.htif_pcr_req_addr   = r_addr;
    assign bus.htif_pcr_req_data   = r_data;
    assign bus.htif_pcr_resp_ready = 1'b1;
    assign stale_cnt               = r_stale;
endmodule
